cache_dma: RTL and testbench
============================

// Module: cache_dma
// PURPOSE
//  Per-cache block transfer engine directly upstream of the shared bus. Takes one block
//  fill (read) or writeback (write) from the cache controller, splits it into
//  dma_data_width_p-word beats on the cache->bus valid/yumi channel (cb_*), collects
//  in-order read beats from the bus, and returns the assembled block to the controller.
// PARAMETERS
//  block_size_p      8  words (32b) per cache block
//  dma_data_width_p  2  words per bus beat; must divide block_size_p; beats_lp = block_size_p/dma_data_width_p
// PORTS
//  clk_i         in   1                     clock
//  nreset_i      in   1                     asynchronous reset, active low
//  req_valid_i   in   1                     controller request valid
//  req_ready_o   out  1                     engine idle, request accepted when valid&ready
//  req_we_i      in   1                     1 = writeback, 0 = fill
//  req_addr_i    in   32                    block address; low $clog2(block_size_p*4) bits ignored
//  req_wdata_i   in   32*block_size_p       writeback data, word 0 in LSBs
//  resp_valid_o  out  1                     transfer complete; held until resp_yumi_i
//  resp_yumi_i   in   1                     controller consumes response
//  resp_data_o   out  32*block_size_p       fill data (valid with resp_valid_o on fills)
//  cb_valid_o    out  1                     beat request to bus
//  cb_yumi_i     in   1                     bus accepts beat this cycle
//  cb_pkt_o      out  cache_bus_pkt_t       {addr, wdata, we} of current beat
//  bus_valid_i   in   1                     read beat returned by bus
//  bus_data_i    in   `DMA_DATA_WIDTH        read beat data
// BEHAVIOUR
//  - Reset (async, nreset_i low): state IDLE, all counters 0, req_ready_o=1, resp_valid_o=0,
//    cb_valid_o=0, cb_pkt_o=0, resp_data_o=0. Reset mid-transfer aborts it; nothing resumes.
//  - States: IDLE -> XFER -> DONE -> IDLE.
//    IDLE: req_ready_o=1; on req_valid_i latch we, aligned base addr, wdata; go XFER.
//    XFER: tx_cnt, rx_cnt (width $clog2(beats_lp+1)). cb_valid_o=1 while tx_cnt<beats_lp.
//      Beat k: addr = base + k*dma_data_width_p*4, we = latched we, wdata = words
//      [k*dma_data_width_p +: dma_data_width_p] (0 on fills). tx_cnt++ on cb_valid_o&cb_yumi_i.
//      Once raised, cb_valid_o and cb_pkt_o hold stable until yumi (no withdraw).
//      Fill: bus_valid_i writes bus_data_i into resp_data_o word slot rx_cnt, rx_cnt++.
//      Reads pipeline: return beats may arrive while later beats are still issuing.
//      Writeback: no return beats; exit when last beat accepted.
//      Fill: exit when last return beat captured (rx_cnt reaches beats_lp).
//    DONE: resp_valid_o=1; on resp_yumi_i -> IDLE. resp_data_o holds until next fill starts.
//  - Latency: request accepted cycle 0 -> cb_valid_o first high cycle 1. Writeback, yumi
//    always 1: beats in cycles 1..beats_lp, resp_valid_o at cycle beats_lp+1.
//    Fill: resp_valid_o the cycle after the last bus_valid_i.
//  - bus_valid_i outside XFER, or on a writeback, or with rx_cnt==tx_cnt (no outstanding
//    beat): ignored, no state change (sim assertion fires).
//  - New request not accepted in the cycle resp_yumi_i retires the old one (IDLE next cycle).
//  - beats_lp==1 legal: single beat; elaboration $error if block_size_p % dma_data_width_p != 0.
// CONFIGURATION
//  CACHE_DMA_PERF_EN defined: adds outputs perf_fill_o[31:0], perf_wb_o[31:0],
//   perf_stall_o[31:0]: completed fills, completed writebacks (increment on resp
//   handshake), cycles with cb_valid_o&!cb_yumi_i. Wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Reset then idle -> req_ready_o=1, cb_valid_o=0, resp_valid_o=0 every cycle.
//  2. Writeback addr 0x1004, wdata words 0..7, yumi=1 -> 4 beats addr 0x1000,08,10,18,
//     we=1, wdata {1,0},{3,2},{5,4},{7,6}; resp_valid_o at cycle 5.
//  3. Fill addr 0x2000, yumi stalled 3 cycles on beat 1 -> cb_pkt_o stable through stall;
//     returns 0xA..0x11 -> resp_data_o words 0..7 = 0xA..0x11 in order.
//  4. Fill with returns interleaved with issue (return beat 0 same cycle beat 2 issues)
//     -> correct assembly, resp_valid_o one cycle after 4th return.
//  5. Spurious bus_valid_i in IDLE, and nreset_i pulsed mid-fill after 2 beats -> no
//     effect / all outputs to reset values; next request runs cleanly from beat 0.
//  6. CACHE_DMA_PERF_EN: 2 fills, 1 writeback, 3 stall cycles -> perf_fill_o=2, perf_wb_o=1,
//     perf_stall_o=3.

Source files
------------

// File: rtl/cache_dma.sv
// cache_dma: moves one cache block between the controller and the shared bus as dma beats.
// Define CACHE_DMA_PERF_EN to add fill/writeback/stall performance counter outputs.
module cache_dma #(
    parameter int block_size_p     = 8,
    parameter int dma_data_width_p = 2
) (
    input  logic                            clk_i,
    input  logic                            nreset_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [31:0]                     req_addr_i,
    input  logic [32*block_size_p-1:0]      req_wdata_i,
    output logic                            resp_valid_o,
    input  logic                            resp_yumi_i,
    output logic [32*block_size_p-1:0]      resp_data_o,
    output logic                            cb_valid_o,
    input  logic                            cb_yumi_i,
    output logic [32+32*dma_data_width_p:0] cb_pkt_o,
`ifdef CACHE_DMA_PERF_EN
    output logic [31:0]                     perf_fill_o,
    output logic [31:0]                     perf_wb_o,
    output logic [31:0]                     perf_stall_o,
`endif
    input  logic                            bus_valid_i,
    input  logic [32*dma_data_width_p-1:0]  bus_data_i
);

    localparam int beats_lp      = block_size_p / dma_data_width_p;
    localparam int beat_w_lp     = 32 * dma_data_width_p;
    localparam int blk_w_lp      = 32 * block_size_p;
    localparam int cnt_w_lp      = $clog2(beats_lp + 1);
    localparam int off_w_lp      = $clog2(block_size_p * 4);
    localparam int beat_bytes_lp = dma_data_width_p * 4;

    localparam logic [cnt_w_lp-1:0] beats_c    = cnt_w_lp'(beats_lp);
    localparam logic [cnt_w_lp-1:0] last_idx_c = cnt_w_lp'(beats_lp - 1);

    if (block_size_p % dma_data_width_p != 0) begin : g_cfg_check
        $error("cache_dma: dma_data_width_p must divide block_size_p");
    end

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [31:0]            base_q, base_d;
    logic [blk_w_lp-1:0]    wdata_q, wdata_d;
    logic [cnt_w_lp-1:0]    tx_q, tx_d, rx_q, rx_d;
    logic [blk_w_lp-1:0]    resp_data_q, resp_data_d;
    logic                   bus_take;
    logic                   beat_fire;
    logic [beat_w_lp-1:0]   wbeat;
    logic                   addr_unused;

    // Offset bits inside the block are dropped when the base address is latched.
    assign addr_unused = ^req_addr_i[off_w_lp-1:0];

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        resp_data_d  = resp_data_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        cb_valid_o   = 1'b0;
        bus_take     = 1'b0;
        beat_fire    = 1'b0;
        wbeat        = '0;
        cb_pkt_o     = '0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    base_d  = {req_addr_i[31:off_w_lp], {off_w_lp{1'b0}}};
                    wdata_d = req_wdata_i;
                    tx_d    = '0;
                    rx_d    = '0;
                    if (!req_we_i) resp_data_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                cb_valid_o = (tx_q < beats_c);
                beat_fire  = cb_valid_o && cb_yumi_i;
                if (beat_fire) tx_d = tx_q + 1'b1;
                // A return beat only counts if some issued beat is still awaiting its data.
                bus_take = bus_valid_i && !we_q && (rx_q < tx_q);
                if (bus_take) rx_d = rx_q + 1'b1;
                if (we_q ? (beat_fire && tx_q == last_idx_c)
                         : (bus_take && rx_q == last_idx_c))
                    state_d = DONE;
            end
            DONE: begin
                resp_valid_o = 1'b1;
                if (resp_yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        for (int k = 0; k < beats_lp; k++) begin
            if (bus_take && rx_q == cnt_w_lp'(k))
                resp_data_d[k*beat_w_lp +: beat_w_lp] = bus_data_i;
            if (we_q && tx_q == cnt_w_lp'(k))
                wbeat = wdata_q[k*beat_w_lp +: beat_w_lp];
        end

        // Packet derives only from latched state and tx_q, so it is stable while stalled.
        if (cb_valid_o)
            cb_pkt_o = {base_q + 32'(tx_q) * 32'(beat_bytes_lp), wbeat, we_q};
    end

    assign resp_data_o = resp_data_q;

    always_ff @(posedge clk_i) begin
        if (nreset_i && bus_valid_i)
            assert (state_q == XFER && !we_q && rx_q < tx_q)
                else $warning("cache_dma: stray bus_valid_i ignored");
    end

`ifdef CACHE_DMA_PERF_EN
    logic [31:0] perf_fill_q, perf_wb_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            perf_fill_q  <= '0;
            perf_wb_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (resp_valid_o && resp_yumi_i) begin
                if (we_q) perf_wb_q   <= perf_wb_q + 32'd1;
                else      perf_fill_q <= perf_fill_q + 32'd1;
            end
            if (cb_valid_o && !cb_yumi_i) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fill_o  = perf_fill_q;
    assign perf_wb_o    = perf_wb_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_cache_dma.sv
// Scoreboard bench for cache_dma: directed transfers push expected beats/responses,
// a negedge monitor pops and compares them as the DUT hands them over.
module tb_cache_dma;

    localparam int BLK   = 8;
    localparam int DW    = 2;
    localparam int BEATS = BLK / DW;

    logic              clk = 1'b0;
    logic              nreset_i;
    logic              req_valid_i, req_ready_o, req_we_i;
    logic [31:0]       req_addr_i;
    logic [32*BLK-1:0] req_wdata_i;
    logic              resp_valid_o, resp_yumi_i;
    logic [32*BLK-1:0] resp_data_o;
    logic              cb_valid_o, cb_yumi_i;
    logic [32+32*DW:0] cb_pkt_o;
    logic              bus_valid_i;
    logic [32*DW-1:0]  bus_data_i;
`ifdef CACHE_DMA_PERF_EN
    logic [31:0]       perf_fill_o, perf_wb_o, perf_stall_o;
`endif

    cache_dma #(.block_size_p(BLK), .dma_data_width_p(DW)) dut (
        .clk_i        (clk),
        .nreset_i     (nreset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_yumi_i  (resp_yumi_i),
        .resp_data_o  (resp_data_o),
        .cb_valid_o   (cb_valid_o),
        .cb_yumi_i    (cb_yumi_i),
        .cb_pkt_o     (cb_pkt_o),
`ifdef CACHE_DMA_PERF_EN
        .perf_fill_o  (perf_fill_o),
        .perf_wb_o    (perf_wb_o),
        .perf_stall_o (perf_stall_o),
`endif
        .bus_valid_i  (bus_valid_i),
        .bus_data_i   (bus_data_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [96:0]       exp_beats[$];
    logic [32*BLK-1:0] exp_resp[$];
    logic [32*BLK-1:0] last_fill_exp = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: beat/response scoreboard plus stall-stability check.
    logic        stall_prev = 1'b0;
    logic [96:0] pkt_prev   = '0;
    always @(negedge clk) begin
        if (stall_prev) begin
            check("stall_valid_held", 256'(cb_valid_o), 256'(1));
            check("stall_pkt_held", 256'(cb_pkt_o), 256'(pkt_prev));
        end
        stall_prev = cb_valid_o && !cb_yumi_i;
        pkt_prev   = cb_pkt_o;
        if (cb_valid_o && cb_yumi_i) begin
            if (exp_beats.size() == 0) check("beat_unexpected", 256'(1), 256'(0));
            else check("beat_pkt", 256'(cb_pkt_o), 256'(exp_beats.pop_front()));
        end
        if (resp_valid_o && resp_yumi_i) begin
            if (exp_resp.size() == 0) check("resp_unexpected", 256'(1), 256'(0));
            else check("resp_data", resp_data_o, exp_resp.pop_front());
        end
    end

    // One transfer: ysched/rsched bit c drives cb_yumi_i/bus_valid_i in cycle c after acceptance.
    task automatic run_xfer(input string name, input logic we, input logic [31:0] addr,
                            input logic [32*BLK-1:0] wd, input logic [31:0] ysched,
                            input logic [31:0] rsched, input logic [31:0] rbase,
                            input int exp_lat);
        logic [31:0]       base;
        logic [63:0]       bw;
        logic [32*BLK-1:0] fill;
        int                r;
        int                lat;
        base = {addr[31:5], 5'b0};
        for (int k = 0; k < BEATS; k++) begin
            bw = we ? wd[k*64 +: 64] : 64'h0;
            exp_beats.push_back({base + 32'(k*8), bw, we});
        end
        if (!we) begin
            for (int i = 0; i < BLK; i++) fill[i*32 +: 32] = rbase + 32'(i);
            last_fill_exp = fill;
        end
        exp_resp.push_back(last_fill_exp);

        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd;
        @(negedge clk);
        check({name, "_req_ready"}, 256'(req_ready_o), 256'(1));
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        r = 0; lat = 0;
        for (int c = 1; c < 32; c++) begin
            cb_yumi_i   = ysched[c];
            bus_valid_i = rsched[c];
            bus_data_i  = {rbase + 32'(2*r+1), rbase + 32'(2*r)};
            if (rsched[c]) r++;
            @(negedge clk);
            if (c == 1) check({name, "_first_beat"}, 256'(cb_valid_o), 256'(1));
            if (resp_valid_o) begin lat = c; break; end
            @(posedge clk); #1;
        end
        check({name, "_latency"}, 256'(lat), 256'(exp_lat));
        @(posedge clk); #1;
        cb_yumi_i = 1'b0; bus_valid_i = 1'b0;
    endtask

    logic [32*BLK-1:0] wd;

    initial begin
        nreset_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        req_wdata_i = '0; resp_yumi_i = 1'b1; cb_yumi_i = 1'b0; bus_valid_i = 1'b0;
        bus_data_i = '0;

        // 1: reset and idle
        @(negedge clk);
        check("rst_req_ready", 256'(req_ready_o), 256'(1));
        check("rst_cb_valid", 256'(cb_valid_o), 256'(0));
        check("rst_resp_valid", 256'(resp_valid_o), 256'(0));
        check("rst_cb_pkt", 256'(cb_pkt_o), 256'(0));
        check("rst_resp_data", resp_data_o, 256'(0));
        @(posedge clk); #1; nreset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_req_ready", 256'(req_ready_o), 256'(1));
            check("idle_cb_valid", 256'(cb_valid_o), 256'(0));
            check("idle_resp_valid", 256'(resp_valid_o), 256'(0));
        end
        @(posedge clk); #1;

        // 2: writeback, no stalls
        for (int i = 0; i < BLK; i++) wd[i*32 +: 32] = 32'(i);
        run_xfer("wb", 1'b1, 32'h1004, wd, 32'h1E, 32'h0, 32'h0, 5);

        // 3: fill with beat 1 stalled three cycles
        run_xfer("fill_stall", 1'b0, 32'h2000, '0, 32'hE2, 32'hF00, 32'hA, 12);

        // 4: fill with returns overlapping issue
        run_xfer("fill_pipe", 1'b0, 32'h2100, '0, 32'h1E, 32'h78, 32'h100, 7);

        // 5a: stray return beats while idle
        bus_valid_i = 1'b1; bus_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); @(posedge clk); #1;
        bus_valid_i = 1'b0;
        @(negedge clk);
        check("stray_req_ready", 256'(req_ready_o), 256'(1));
        check("stray_resp_valid", 256'(resp_valid_o), 256'(0));
        check("stray_resp_data", resp_data_o, last_fill_exp);
        @(posedge clk); #1;

        // 5b: reset pulsed after two beats of a fill
        exp_beats.push_back({32'h3000, 64'h0, 1'b0});
        exp_beats.push_back({32'h3008, 64'h0, 1'b0});
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h3000;
        @(posedge clk); #1;
        req_valid_i = 1'b0; cb_yumi_i = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        cb_yumi_i = 1'b0; nreset_i = 1'b0;
        @(negedge clk);
        check("abort_req_ready", 256'(req_ready_o), 256'(1));
        check("abort_cb_valid", 256'(cb_valid_o), 256'(0));
        check("abort_resp_valid", 256'(resp_valid_o), 256'(0));
        check("abort_cb_pkt", 256'(cb_pkt_o), 256'(0));
        check("abort_resp_data", resp_data_o, 256'(0));
`ifdef CACHE_DMA_PERF_EN
        check("abort_perf", {perf_fill_o, perf_wb_o, perf_stall_o}, 256'(0));
`endif
        @(posedge clk); #1;
        nreset_i = 1'b1; last_fill_exp = '0;
        run_xfer("fill_after_rst", 1'b0, 32'h3040, '0, 32'h1E, 32'h3C, 32'h200, 6);

        // 6: writeback with three stall cycles on beat 2, then a second fill
        for (int i = 0; i < BLK; i++) wd[i*32 +: 32] = 32'h40 + 32'(i);
        run_xfer("wb_stall", 1'b1, 32'h4000, wd, 32'hC6, 32'h0, 32'h0, 8);
        run_xfer("fill_b", 1'b0, 32'h5010, '0, 32'h1E, 32'h1E0, 32'h300, 9);
`ifdef CACHE_DMA_PERF_EN
        check("perf_fill", 256'(perf_fill_o), 256'(2));
        check("perf_wb", 256'(perf_wb_o), 256'(1));
        check("perf_stall", 256'(perf_stall_o), 256'(3));
`endif

        @(posedge clk); #1;
        check("beats_drained", 256'(exp_beats.size()), 256'(0));
        check("resps_drained", 256'(exp_resp.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "tb_cache_dma timeout");
    end

endmodule
